// File: rtl/pulse_avg_accumulator.sv
// Running-sum stage of the pulse averager: joins each new pulse sample with the
// stored partial sum, adds them per I/Q component and routes the result to the buffer or the output.
module pulse_avg_accumulator #(
  parameter int MAX_LOG2_AVG = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] pulse_len,
  input  logic [3:0]  log2_avg,
  output logic        busy,
  output logic        done,
  output logic        len_err,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  input  logic [31:0] a_axis_tdata,
  input  logic        a_axis_tvalid,
  input  logic        a_axis_tlast,
  output logic        a_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [3:0]  m_axis_tkeep,
  output logic [31:0] o_axis_tdata,
  output logic        o_axis_tvalid,
  output logic        o_axis_tlast,
  input  logic        o_axis_tready,
  output logic [3:0]  o_axis_tkeep
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | joining samples and accumulating pulses
  // DRAIN | final averaged sample held until o_axis accepts it
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [3:0] K_MAX = 4'(MAX_LOG2_AVG);

  state_t      state, state_nxt;
  logic [31:0] plen_r;
  logic [3:0]  k_r;
  logic [31:0] samp_cnt;
  logic [8:0]  pulse_cnt;
  logic        out_valid, out_to_o, out_last;
  logic [31:0] out_data;
  logic        len_err_r, done_r;

  logic        first_pulse, last_pulse, samp_last, out_free, fire, start_acc, drain_hs;
  logic signed [15:0] s_i, s_q;
  logic [15:0] sum_i, sum_q;

  function automatic logic [15:0] sat_add(input logic signed [15:0] x,
                                          input logic signed [15:0] y,
                                          input logic use_y);
    logic signed [16:0] s;
    s = $signed({x[15], x}) + (use_y ? $signed({y[15], y}) : 17'sd0);
    if (s > 17'sd32767)       return 16'h7FFF;
    else if (s < -17'sd32768) return 16'h8000;
    else                      return s[15:0];
  endfunction

  assign first_pulse = (pulse_cnt == 9'd0);
  assign last_pulse  = (pulse_cnt == ((9'd1 << k_r) - 9'd1));
  assign samp_last   = (samp_cnt == plen_r - 32'd1);
  assign out_free    = !out_valid || (out_to_o ? o_axis_tready : m_axis_tready);
  assign fire        = (state == RUN) && !reset && !clear && s_axis_tvalid &&
                       (first_pulse || a_axis_tvalid) && out_free;
  assign start_acc   = (state == IDLE) && start;
  assign drain_hs    = (state == DRAIN) && out_valid && out_to_o && o_axis_tready;

  // Pre-scale each component before the add so the running sum never exceeds 16 bits.
  assign s_i   = $signed(s_axis_tdata[31:16]) >>> k_r;
  assign s_q   = $signed(s_axis_tdata[15:0]) >>> k_r;
  assign sum_i = sat_add(s_i, $signed(a_axis_tdata[31:16]), !first_pulse);
  assign sum_q = sat_add(s_q, $signed(a_axis_tdata[15:0]), !first_pulse);

  always_ff @(posedge clk) begin
    if (reset || clear) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (fire && samp_last && last_pulse) state_nxt = DRAIN;
      DRAIN:   if (drain_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration survives clear; only reset returns it to defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      plen_r <= 32'd1;
      k_r    <= 4'd0;
    end else if (!clear && start_acc) begin
      plen_r <= (pulse_len == 32'd0) ? 32'd1 : pulse_len;
      k_r    <= (log2_avg > K_MAX) ? K_MAX : log2_avg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      samp_cnt  <= 32'd0;
      pulse_cnt <= 9'd0;
      out_valid <= 1'b0;
      out_to_o  <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 32'd0;
      len_err_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= drain_hs;
      if (start_acc) begin
        samp_cnt  <= 32'd0;
        pulse_cnt <= 9'd0;
        len_err_r <= 1'b0;
      end else if (fire) begin
        if (samp_last) begin
          samp_cnt  <= 32'd0;
          pulse_cnt <= pulse_cnt + 9'd1;
        end else begin
          samp_cnt <= samp_cnt + 32'd1;
        end
        if ((s_axis_tlast != samp_last) || (!first_pulse && (a_axis_tlast != samp_last)))
          len_err_r <= 1'b1;
      end
      if (fire) begin
        out_valid <= 1'b1;
        out_to_o  <= last_pulse;
        out_last  <= samp_last;
        out_data  <= {sum_i, sum_q};
      end else if (out_valid && out_free) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign done          = done_r;
  assign len_err       = len_err_r;
  assign s_axis_tready = fire;
  assign a_axis_tready = fire && !first_pulse;
  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid && !out_to_o;
  assign m_axis_tlast  = out_last;
  assign m_axis_tkeep  = 4'hF;
  assign o_axis_tdata  = out_data;
  assign o_axis_tvalid = out_valid && out_to_o;
  assign o_axis_tlast  = out_last;
  assign o_axis_tkeep  = 4'hF;

endmodule

// File: tb/tb_pulse_avg_accumulator.sv
// Bench for pulse_avg_accumulator: stream drivers with a buffer loopback model,
// and sinks that compare against an arithmetic averaging reference.
module tb_pulse_avg_accumulator;
  logic        clk = 1'b0;
  logic        reset, clear, start;
  logic [31:0] pulse_len;
  logic [3:0]  log2_avg;
  logic        busy, done, len_err;
  logic [31:0] s_axis_tdata, a_axis_tdata, m_axis_tdata, o_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic        a_axis_tvalid, a_axis_tlast, a_axis_tready;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        o_axis_tvalid, o_axis_tlast, o_axis_tready;
  logic [3:0]  m_axis_tkeep, o_axis_tkeep;

  pulse_avg_accumulator #(.MAX_LOG2_AVG(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .pulse_len(pulse_len), .log2_avg(log2_avg),
    .busy(busy), .done(done), .len_err(len_err),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .a_axis_tdata(a_axis_tdata), .a_axis_tvalid(a_axis_tvalid),
    .a_axis_tlast(a_axis_tlast), .a_axis_tready(a_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .m_axis_tkeep(m_axis_tkeep),
    .o_axis_tdata(o_axis_tdata), .o_axis_tvalid(o_axis_tvalid),
    .o_axis_tlast(o_axis_tlast), .o_axis_tready(o_axis_tready),
    .o_axis_tkeep(o_axis_tkeep)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [32:0] s_q[$], bram_q[$], exp_m[$], exp_o[$];
  logic [31:0] sdat[$];
  logic        stl[$];
  int          gap = 0;
  bit          loopback = 1'b1;
  logic [31:0] forced = 32'd0;
  int          m_cnt, o_cnt, a_cnt, last_cnt, done_cnt, done_cyc, o_hs_cyc;
  bit          a_ready_seen;
  logic [31:0] o_last_data;
  bit          s_acc, a_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every pulse adds floor(sample / 2^k) to the running sum of its sample slot.
  task automatic build(input int ep, input int k);
    int np;
    int ai[], aq[];
    np = 1 << k;
    ai = new[ep];
    aq = new[ep];
    for (int p = 0; p < np; p++) begin
      for (int j = 0; j < ep; j++) begin
        logic [31:0] d;
        int vi, vq;
        logic [15:0] wi, wq;
        d  = sdat[p*ep + j];
        vi = int'($signed(d[31:16])) >>> k;
        vq = int'($signed(d[15:0])) >>> k;
        if (p > 0) begin
          vi += loopback ? ai[j] : int'($signed(forced[31:16]));
          vq += loopback ? aq[j] : int'($signed(forced[15:0]));
        end
        vi = (vi > 32767) ? 32767 : ((vi < -32768) ? -32768 : vi);
        vq = (vq > 32767) ? 32767 : ((vq < -32768) ? -32768 : vq);
        ai[j] = vi;
        aq[j] = vq;
        wi = 16'(vi);
        wq = 16'(vq);
        if (p == np - 1) exp_o.push_back({(j == ep - 1), wi, wq});
        else             exp_m.push_back({(j == ep - 1), wi, wq});
        s_q.push_back({stl[p*ep + j], d});
      end
    end
  endtask

  task automatic fill(input int ep, input int np, input int mode);
    sdat.delete();
    stl.delete();
    for (int p = 0; p < np; p++) begin
      for (int j = 0; j < ep; j++) begin
        case (mode)
          0:       sdat.push_back({16'(100 + j), 16'hFFFF});
          1:       sdat.push_back({16'd400, 16'hFE70});
          2:       sdat.push_back(32'h7FFF8000);
          3:       sdat.push_back(32'h7FFF7FFF);
          default: sdat.push_back($urandom);
        endcase
        stl.push_back(j == ep - 1);
      end
    end
  endtask

  task automatic clr_counts();
    m_cnt = 0; o_cnt = 0; a_cnt = 0; last_cnt = 0; done_cnt = 0;
    a_ready_seen = 1'b0;
  endtask

  task automatic run_cycle(input int plen, input int lg, input bit exp_lerr, input string tag);
    int k, ep, t;
    k  = (lg > 8) ? 8 : lg;
    ep = (plen == 0) ? 1 : plen;
    build(ep, k);
    clr_counts();
    @(posedge clk); #2;
    pulse_len = 32'(plen);
    log2_avg  = 4'(lg);
    start     = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_lerr_start"}, len_err, 0);
    t = 0;
    while (done_cnt == 0 && t < 30000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, (done_cnt != 0), 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done_lat"}, done_cyc, o_hs_cyc + 1);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_exp_m_left"}, exp_m.size(), 0);
    chk({tag, "_exp_o_left"}, exp_o.size(), 0);
    chk({tag, "_lerr_end"}, len_err, exp_lerr);
  endtask

  initial begin
    s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0;
    forever begin
      @(negedge clk);
      s_acc = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (s_acc) begin
        if (s_q.size() > 0) void'(s_q.pop_front());
        s_axis_tvalid = 1'b0;
      end
      if (!s_axis_tvalid && s_q.size() > 0 && int'($urandom_range(99)) >= gap) begin
        s_axis_tvalid = 1'b1;
        {s_axis_tlast, s_axis_tdata} = s_q[0];
      end
    end
  end

  initial begin
    a_axis_tvalid = 0; a_axis_tdata = 0; a_axis_tlast = 0;
    forever begin
      @(negedge clk);
      a_acc = a_axis_tvalid && a_axis_tready;
      @(posedge clk); #1;
      if (a_acc) begin
        if (bram_q.size() > 0) void'(bram_q.pop_front());
        a_axis_tvalid = 1'b0;
        a_cnt++;
      end
      if (!a_axis_tvalid && bram_q.size() > 0 && int'($urandom_range(99)) >= gap) begin
        a_axis_tvalid = 1'b1;
        {a_axis_tlast, a_axis_tdata} = bram_q[0];
      end
    end
  end

  initial begin
    m_axis_tready = 0; o_axis_tready = 0;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = (int'($urandom_range(99)) >= gap);
      o_axis_tready = (int'($urandom_range(99)) >= gap);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (a_axis_tready) a_ready_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        m_cnt++;
        if (m_axis_tlast) last_cnt++;
        assert (exp_m.size() != 0) else begin
          errors++;
          $error("FAIL m_extra observed=%0h expected=none", {m_axis_tlast, m_axis_tdata});
        end
        if (exp_m.size() != 0) chk("m_word", {m_axis_tlast, m_axis_tdata}, exp_m.pop_front());
        if (loopback) bram_q.push_back({m_axis_tlast, m_axis_tdata});
      end
      if (o_axis_tvalid && o_axis_tready) begin
        o_cnt++;
        o_hs_cyc = cyc;
        o_last_data = o_axis_tdata;
        if (o_axis_tlast) last_cnt++;
        assert (exp_o.size() != 0) else begin
          errors++;
          $error("FAIL o_extra observed=%0h expected=none", {o_axis_tlast, o_axis_tdata});
        end
        if (exp_o.size() != 0) chk("o_word", {o_axis_tlast, o_axis_tdata}, exp_o.pop_front());
      end
    end
  end

  initial begin
    int t;
    reset = 1'b1; clear = 1'b0; start = 1'b0; pulse_len = 32'd0; log2_avg = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lerr", len_err, 0);
    chk("rst_valids", {m_axis_tvalid, o_axis_tvalid}, 0);
    chk("rst_readys", {s_axis_tready, a_axis_tready}, 0);
    chk("rst_tdata", {m_axis_tdata, o_axis_tdata}, 0);
    chk("rst_tkeep", {m_axis_tkeep, o_axis_tkeep}, 8'hFF);
    @(posedge clk); #2;
    reset = 1'b0;

    fill(4, 1, 0);
    run_cycle(4, 0, 0, "k0");
    chk("k0_o_cnt", o_cnt, 4);
    chk("k0_m_cnt", m_cnt, 0);
    chk("k0_a_ready", a_ready_seen, 0);
    chk("k0_last_cnt", last_cnt, 1);
    chk("k0_o_final", o_last_data, 32'h0067FFFF);

    fill(8, 4, 1);
    run_cycle(8, 2, 0, "k2");
    chk("k2_m_cnt", m_cnt, 24);
    chk("k2_a_cnt", a_cnt, 24);
    chk("k2_o_cnt", o_cnt, 8);
    chk("k2_last_cnt", last_cnt, 4);
    chk("k2_o_final", o_last_data, 32'h0190FE70);

    fill(2, 2, 2);
    run_cycle(2, 1, 0, "trunc");
    chk("trunc_o_final", o_last_data, 32'h7FFE8000);

    loopback = 1'b0;
    forced = 32'h7FFF7FFF;
    bram_q.push_back({1'b0, 32'h7FFF7FFF});
    bram_q.push_back({1'b1, 32'h7FFF7FFF});
    fill(2, 2, 3);
    run_cycle(2, 1, 0, "sat");
    chk("sat_o_final", o_last_data, 32'h7FFF7FFF);
    chk("sat_a_cnt", a_cnt, 2);
    loopback = 1'b1;
    bram_q.delete();

    gap = 30;
    fill(64, 8, 4);
    run_cycle(64, 3, 0, "rand");
    chk("rand_o_cnt", o_cnt, 64);
    chk("rand_m_cnt", m_cnt, 448);
    chk("rand_a_cnt", a_cnt, 448);
    chk("rand_last_cnt", last_cnt, 8);
    gap = 0;

    fill(1, 1, 0);
    run_cycle(0, 0, 0, "len0");
    chk("len0_o_cnt", o_cnt, 1);
    chk("len0_last_cnt", last_cnt, 1);

    fill(8, 1, 0);
    stl[5] = 1'b1;
    stl[7] = 1'b0;
    run_cycle(8, 0, 1, "lerr");
    chk("lerr_o_cnt", o_cnt, 8);
    chk("lerr_last_cnt", last_cnt, 1);
    fill(4, 1, 0);
    run_cycle(4, 0, 0, "lerr_next");

    fill(8, 4, 1);
    build(8, 2);
    clr_counts();
    @(posedge clk); #2;
    pulse_len = 32'd8;
    log2_avg  = 4'd2;
    start     = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    t = 0;
    while (a_cnt < 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("clr_reached_pulse1", (a_cnt >= 3), 1);
    @(posedge clk); #2;
    clear = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_valids", {m_axis_tvalid, o_axis_tvalid}, 0);
    chk("clr_readys", {s_axis_tready, a_axis_tready}, 0);
    s_q.delete(); bram_q.delete(); exp_m.delete(); exp_o.delete();
    s_axis_tvalid = 1'b0;
    a_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    fill(8, 4, 1);
    run_cycle(8, 2, 0, "after_clr");
    chk("after_clr_o_cnt", o_cnt, 8);
    chk("after_clr_m_cnt", m_cnt, 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
